// File: rtl/golf_pkg.sv
// Shared golf types: terrain codes, map geometry and probe indexing.
package golf_pkg;

    typedef enum logic [1:0] {
        FAIRWAY = 2'd0,
        SAND    = 2'd1,
        WALL    = 2'd2,
        HOLE    = 2'd3
    } terrain_t;

    localparam int unsigned MAP_WIDTH  = 128;
    localparam int unsigned MAP_HEIGHT = 128;
    localparam int unsigned ADDR_W     = 14;

    // Probe index 0..4, issued in this order.
    typedef logic [2:0] probe_idx_t;

    localparam probe_idx_t PROBE_C  = 3'd0;
    localparam probe_idx_t PROBE_XP = 3'd1;
    localparam probe_idx_t PROBE_XN = 3'd2;
    localparam probe_idx_t PROBE_YP = 3'd3;
    localparam probe_idx_t PROBE_YN = 3'd4;

endpackage

// File: rtl/map_probe_addr.sv
// Combinational probe-point address generator with out-of-bounds detection.
module map_probe_addr
    import golf_pkg::*;
(
    input  logic [7:0]        cx,
    input  logic [7:0]        cy,
    input  probe_idx_t        probe,
    input  logic [2:0]        radius,
    output logic [ADDR_W-1:0] addr,
    output logic              oob
);

    logic [9:0] px;
    logic [9:0] py;
    logic [9:0] r;

    // Offset the centre by the radius on one axis; bit 9 set means negative.
    always_comb begin
        r  = {7'b0, radius};
        px = {2'b00, cx};
        py = {2'b00, cy};
        case (probe)
            PROBE_XP: px = {2'b00, cx} + r;
            PROBE_XN: px = {2'b00, cx} - r;
            PROBE_YP: py = {2'b00, cy} + r;
            PROBE_YN: py = {2'b00, cy} - r;
            default:  ;
        endcase
        oob = px[9] || (px[8:0] >= 9'(MAP_WIDTH)) ||
              py[9] || (py[8:0] >= 9'(MAP_HEIGHT));
        if (oob) begin
            addr = '0;
        end else begin
            addr = ADDR_W'(py[8:0]) * ADDR_W'(MAP_WIDTH) + ADDR_W'(px[8:0]);
        end
    end

endmodule

// File: rtl/collision_checker.sv
// Five-point terrain probe around the ball, reading a shared fixed-latency BRAM.
module collision_checker
    import golf_pkg::*;
#(
    parameter int unsigned BALL_RADIUS  = 2,
    parameter int unsigned READ_LATENCY = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        start,
    input  logic [15:0] ball_x,
    input  logic [15:0] ball_y,
    output logic [13:0] terrain_addr,
    input  logic [1:0]  terrain_data,
    output logic        busy,
    output logic        done,
    output logic        hit_xp,
    output logic        hit_xn,
    output logic        hit_yp,
    output logic        hit_yn,
    output logic        in_hole,
    output logic [1:0]  center_terrain
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StIssue = 2'd1;
    localparam logic [1:0] StDrain = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    logic [1:0] state;
    logic [2:0] cnt;
    logic [7:0] cx_lat;
    logic [7:0] cy_lat;

    // Tag registered alongside terrain_addr, then delayed to line up with terrain_data.
    logic       addr_vld;
    logic       addr_oob;
    probe_idx_t addr_idx;
    logic       pipe_vld [READ_LATENCY];
    logic       pipe_oob [READ_LATENCY];
    probe_idx_t pipe_idx [READ_LATENCY];

    terrain_t   cap [5];

    logic        accept;
    logic        issue_now;
    logic [7:0]  gen_cx;
    logic [7:0]  gen_cy;
    probe_idx_t  gen_idx;
    logic [13:0] gen_addr;
    logic        gen_oob;
    terrain_t    eff_data;
    logic        unused_frac;

    assign unused_frac = ^{ball_x[7:0], ball_y[7:0]};
    assign busy        = (state == StIssue) || (state == StDrain);

    // Probe 0 comes straight from the inputs on accept; later probes use the latched centre.
    always_comb begin
        accept    = start && ((state == StIdle) || (state == StDone));
        issue_now = accept || ((state == StIssue) && (cnt != 3'd4));
        gen_cx    = accept ? ball_x[15:8] : cx_lat;
        gen_cy    = accept ? ball_y[15:8] : cy_lat;
        gen_idx   = accept ? PROBE_C : probe_idx_t'(cnt + 3'd1);
        eff_data  = pipe_oob[READ_LATENCY-1] ? WALL : terrain_t'(terrain_data);
    end

    map_probe_addr u_probe (
        .cx     (gen_cx),
        .cy     (gen_cy),
        .probe  (gen_idx),
        .radius (3'(BALL_RADIUS)),
        .addr   (gen_addr),
        .oob    (gen_oob)
    );

    // FSM, address issue, tag pipeline and result capture.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state          <= StIdle;
            cnt            <= '0;
            cx_lat         <= '0;
            cy_lat         <= '0;
            terrain_addr   <= '0;
            addr_vld       <= 1'b0;
            addr_oob       <= 1'b0;
            addr_idx       <= '0;
            done           <= 1'b0;
            hit_xp         <= 1'b0;
            hit_xn         <= 1'b0;
            hit_yp         <= 1'b0;
            hit_yn         <= 1'b0;
            in_hole        <= 1'b0;
            center_terrain <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_vld[i] <= 1'b0;
                pipe_oob[i] <= 1'b0;
                pipe_idx[i] <= '0;
            end
            for (int i = 0; i < 5; i++) begin
                cap[i] <= FAIRWAY;
            end
        end else begin
            done <= 1'b0;

            if (issue_now) begin
                terrain_addr <= gen_addr;
                addr_vld     <= 1'b1;
                addr_oob     <= gen_oob;
                addr_idx     <= gen_idx;
            end else begin
                terrain_addr <= '0;
                addr_vld     <= 1'b0;
                addr_oob     <= 1'b0;
                addr_idx     <= '0;
            end

            if (accept) begin
                cx_lat <= ball_x[15:8];
                cy_lat <= ball_y[15:8];
                state  <= StIssue;
                cnt    <= '0;
            end else begin
                case (state)
                    StIssue: begin
                        if (cnt == 3'd4) begin
                            state <= StDrain;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 3'd1;
                        end
                    end
                    StDrain: begin
                        if (cnt == 3'(READ_LATENCY - 1)) begin
                            state <= StDone;
                            done  <= 1'b1;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 3'd1;
                        end
                    end
                    StDone:  state <= StIdle;
                    default: state <= StIdle;
                endcase
            end

            pipe_vld[0] <= addr_vld;
            pipe_oob[0] <= addr_oob;
            pipe_idx[0] <= addr_idx;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_oob[i] <= pipe_oob[i-1];
                pipe_idx[i] <= pipe_idx[i-1];
            end

            // Last probe's data is used directly so outputs update on the edge into DONE.
            if (pipe_vld[READ_LATENCY-1]) begin
                cap[pipe_idx[READ_LATENCY-1]] <= eff_data;
                if (pipe_idx[READ_LATENCY-1] == PROBE_YN) begin
                    center_terrain <= cap[PROBE_C];
                    in_hole        <= (cap[PROBE_C] == HOLE);
                    hit_xp         <= (cap[PROBE_XP] == WALL);
                    hit_xn         <= (cap[PROBE_XN] == WALL);
                    hit_yp         <= (cap[PROBE_YP] == WALL);
                    hit_yn         <= (eff_data == WALL);
                end
            end
        end
    end

endmodule
